st2_branch_resolver: RTL and testbench

- Parametrised, registered successor to the stage-2 combinational comparator.
- Compares the stage-2 operand against the reference register (reg15), with a signed or unsigned mode, and evaluates a selectable branch condition.
- Registers the outcome with valid, stall and flush control.
- Keeps a small table of 2-bit saturating branch predictors and a saturating mispredict counter, which feed stage-1 fetch steering and performance monitoring.

---
 rtl/st2_branch_resolver_if.sv | 35 +++
 rtl/st2_branch_resolver.sv | 133 +++++++++++++
 tb/tb_st2_branch_resolver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/st2_branch_resolver_if.sv
// Stage-2 branch resolver bus: operands, condition, predictor query and the registered result.
interface st2_branch_resolver_if #(
    parameter int WIDTH      = 16,
    parameter int PRED_IDX_W = 3,
    parameter int MISS_CNT_W = 8
);
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic [WIDTH-1:0]      op1;
    logic [WIDTH-1:0]      reg15;
    logic                  signed_mode;
    logic [2:0]            cond;
    logic [PRED_IDX_W-1:0] pc_idx;
    logic                  predicted_taken;
    logic [PRED_IDX_W-1:0] query_idx;
    logic                  query_taken;
    logic                  out_valid;
    logic [1:0]            cmp_result;
    logic                  taken;
    logic                  mispredict;
    logic [MISS_CNT_W-1:0] miss_count;

    modport master (
        output in_valid, stall, flush, op1, reg15, signed_mode, cond,
               pc_idx, predicted_taken, query_idx,
        input  query_taken, out_valid, cmp_result, taken, mispredict, miss_count
    );

    modport slave (
        input  in_valid, stall, flush, op1, reg15, signed_mode, cond,
               pc_idx, predicted_taken, query_idx,
        output query_taken, out_valid, cmp_result, taken, mispredict, miss_count
    );
endinterface

// File: rtl/st2_branch_resolver.sv
// Registered stage-2 branch resolver: compare, condition evaluation, 2-bit predictor
// table training and a saturating mispredict counter.
module st2_branch_resolver #(
    parameter int WIDTH      = 16,
    parameter int PRED_IDX_W = 3,
    parameter int MISS_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    st2_branch_resolver_if.slave bus
);
    localparam int N_PRED = 1 << PRED_IDX_W;

    typedef enum logic [2:0] {
        C_BEQ    = 3'b000,
        C_BNE    = 3'b001,
        C_BLT    = 3'b010,
        C_BGT    = 3'b011,
        C_BLE    = 3'b100,
        C_BGE    = 3'b101,
        C_ALWAYS = 3'b110,
        C_NEVER  = 3'b111
    } cond_e;

    logic                  out_valid_q, out_valid_d;
    logic [1:0]            cmp_result_q, cmp_result_d;
    logic                  taken_q, taken_d;
    logic                  mispredict_q, mispredict_d;
    logic [MISS_CNT_W-1:0] miss_count_q, miss_count_d;
    logic [1:0]            pred_q [N_PRED];
    logic [1:0]            pred_d [N_PRED];

    logic       lt, gt, eq;
    logic [1:0] cmp_code;
    logic       cond_true;

    always_comb begin
        eq = (bus.op1 == bus.reg15);
        if (bus.signed_mode) begin
            lt = ($signed(bus.op1) < $signed(bus.reg15));
        end else begin
            lt = (bus.op1 < bus.reg15);
        end
        gt = !lt && !eq;
        cmp_code = eq ? 2'b11 : (lt ? 2'b01 : 2'b10);
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(bus.cond))
            C_BEQ:    cond_true = eq;
            C_BNE:    cond_true = !eq;
            C_BLT:    cond_true = lt;
            C_BGT:    cond_true = gt;
            C_BLE:    cond_true = lt | eq;
            C_BGE:    cond_true = gt | eq;
            C_ALWAYS: cond_true = 1'b1;
            C_NEVER:  cond_true = 1'b0;
            default:  cond_true = 1'b0;
        endcase
    end

    // Flush beats stall beats capture; reset is handled in the register block.
    always_comb begin
        out_valid_d  = out_valid_q;
        cmp_result_d = cmp_result_q;
        taken_d      = taken_q;
        mispredict_d = mispredict_q;
        miss_count_d = miss_count_q;
        pred_d       = pred_q;

        if (bus.flush) begin
            out_valid_d  = 1'b0;
            cmp_result_d = 2'b00;
            taken_d      = 1'b0;
            mispredict_d = 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                out_valid_d  = 1'b1;
                cmp_result_d = cmp_code;
                taken_d      = cond_true;
                mispredict_d = cond_true ^ bus.predicted_taken;
                if (cond_true) begin
                    if (pred_q[bus.pc_idx] != 2'b11) begin
                        pred_d[bus.pc_idx] = pred_q[bus.pc_idx] + 2'b01;
                    end
                end else begin
                    if (pred_q[bus.pc_idx] != 2'b00) begin
                        pred_d[bus.pc_idx] = pred_q[bus.pc_idx] - 2'b01;
                    end
                end
                if (mispredict_d && (miss_count_q != {MISS_CNT_W{1'b1}})) begin
                    miss_count_d = miss_count_q + 1'b1;
                end
            end else begin
                out_valid_d  = 1'b0;
                cmp_result_d = 2'b00;
                taken_d      = 1'b0;
                mispredict_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            cmp_result_q <= 2'b00;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            miss_count_q <= '0;
            for (int i = 0; i < N_PRED; i++) begin
                pred_q[i] <= 2'b01;
            end
        end else begin
            out_valid_q  <= out_valid_d;
            cmp_result_q <= cmp_result_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            miss_count_q <= miss_count_d;
            for (int i = 0; i < N_PRED; i++) begin
                pred_q[i] <= pred_d[i];
            end
        end
    end

    // Query reads the stored counter directly; an update at the same index shows next cycle.
    assign bus.query_taken = pred_q[bus.query_idx][1];
    assign bus.out_valid   = out_valid_q;
    assign bus.cmp_result  = cmp_result_q;
    assign bus.taken       = taken_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.miss_count  = miss_count_q;
endmodule

// File: tb/tb_st2_branch_resolver.sv
// Randomized and directed bench for st2_branch_resolver against a behavioural model.
module tb_st2_branch_resolver;
    localparam int WIDTH      = 16;
    localparam int PRED_IDX_W = 3;
    localparam int MISS_CNT_W = 8;
    localparam int N_PRED     = 1 << PRED_IDX_W;
    localparam int MISS_MAX   = (1 << MISS_CNT_W) - 1;

    logic clk;
    logic rst_n;

    st2_branch_resolver_if #(.WIDTH(WIDTH), .PRED_IDX_W(PRED_IDX_W), .MISS_CNT_W(MISS_CNT_W)) bus ();

    st2_branch_resolver #(.WIDTH(WIDTH), .PRED_IDX_W(PRED_IDX_W), .MISS_CNT_W(MISS_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    int  m_pred [N_PRED];
    int  m_miss;
    bit  m_valid;
    int  m_cmp;
    bit  m_taken;
    bit  m_misp;
    bit  m_known = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint to_num(input logic [WIDTH-1:0] v, input bit sgn);
        longint r;
        r = longint'(v);
        if (sgn && v[WIDTH-1]) r = r - (longint'(1) << WIDTH);
        return r;
    endfunction

    // One clock: drive inputs, check the pre-edge query, step the model, check outputs.
    task automatic cycle(input bit rst, input bit iv, input bit st, input bit fl,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit sm, input logic [2:0] c,
                         input int pc, input bit pt, input int q);
        longint x, y;
        bit lt, gt, eq, tk;
        rst_n               = rst;
        bus.in_valid        = iv;
        bus.stall           = st;
        bus.flush           = fl;
        bus.op1             = a;
        bus.reg15           = b;
        bus.signed_mode     = sm;
        bus.cond            = c;
        bus.pc_idx          = PRED_IDX_W'(pc);
        bus.predicted_taken = pt;
        bus.query_idx       = PRED_IDX_W'(q);
        #1;
        if (m_known) check("query_pre", 32'(bus.query_taken), 32'(m_pred[q] >= 2));
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_cmp = 0; m_taken = 0; m_misp = 0; m_miss = 0;
            foreach (m_pred[i]) m_pred[i] = 1;
            m_known = 1;
        end else if (fl) begin
            m_valid = 0; m_cmp = 0; m_taken = 0; m_misp = 0;
        end else if (st) begin
            // hold everything
        end else if (iv) begin
            x = to_num(a, sm);
            y = to_num(b, sm);
            lt = x < y; gt = x > y; eq = x == y;
            case (c)
                3'd0: tk = eq;
                3'd1: tk = !eq;
                3'd2: tk = lt;
                3'd3: tk = gt;
                3'd4: tk = lt || eq;
                3'd5: tk = gt || eq;
                3'd6: tk = 1;
                default: tk = 0;
            endcase
            m_valid = 1;
            m_cmp   = eq ? 3 : (lt ? 1 : 2);
            m_taken = tk;
            m_misp  = tk != pt;
            m_pred[pc] = tk ? ((m_pred[pc] < 3) ? m_pred[pc] + 1 : 3)
                            : ((m_pred[pc] > 0) ? m_pred[pc] - 1 : 0);
            if (m_misp && m_miss < MISS_MAX) m_miss++;
        end else begin
            m_valid = 0; m_cmp = 0; m_taken = 0; m_misp = 0;
        end
        #1;
        check("out_valid",  32'(bus.out_valid),  32'(m_valid));
        check("cmp_result", 32'(bus.cmp_result), 32'(m_cmp));
        check("taken",      32'(bus.taken),      32'(m_taken));
        check("mispredict", 32'(bus.mispredict), 32'(m_misp));
        check("miss_count", 32'(bus.miss_count), 32'(m_miss));
        check("query_post", 32'(bus.query_taken), 32'(m_pred[q] >= 2));
    endtask

    task automatic idle(input bit rst, input int q);
        cycle(rst, 0, 0, 0, '0, '0, 0, 3'd7, 0, 0, q);
    endtask

    initial begin
        logic [1:0] held_cmp;
        logic [MISS_CNT_W-1:0] held_miss;

        // Reset and idle, query every entry
        idle(0, 0);
        idle(0, 0);
        for (int i = 0; i < N_PRED; i++) begin
            idle(1, i);
            check("rst_query", 32'(bus.query_taken), 32'd0);
        end
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_cmp",   32'(bus.cmp_result), 32'd0);
        check("rst_miss",  32'(bus.miss_count), 32'd0);

        // Signed vs unsigned BLT
        cycle(1, 1, 0, 0, 16'h8000, 16'h0001, 1, 3'd2, 0, 1, 0);
        check("blt_signed_cmp", 32'(bus.cmp_result), 32'd1);
        check("blt_signed_tk",  32'(bus.taken), 32'd1);
        cycle(1, 1, 0, 0, 16'h8000, 16'h0001, 0, 3'd2, 0, 0, 0);
        check("blt_unsigned_cmp", 32'(bus.cmp_result), 32'd2);
        check("blt_unsigned_tk",  32'(bus.taken), 32'd0);

        // BLE on equal operands after a fresh reset
        idle(0, 0);
        cycle(1, 1, 0, 0, 16'h1234, 16'h1234, 0, 3'd4, 1, 0, 0);
        check("ble_cmp",  32'(bus.cmp_result), 32'd3);
        check("ble_tk",   32'(bus.taken), 32'd1);
        check("ble_misp", 32'(bus.mispredict), 32'd1);
        check("ble_miss", 32'(bus.miss_count), 32'd1);

        // Train entry 5 up to saturation, then back down
        check("p5_before", 32'(bus.query_taken), 32'd0);
        cycle(1, 1, 0, 0, 16'h0, 16'h0, 0, 3'd6, 5, 1, 5);
        check("p5_after1", 32'(bus.query_taken), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 16'h0, 16'h0, 0, 3'd6, 5, 1, 5);
        check("p5_sat_hi", 32'(m_pred[5]), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 16'h0, 16'h0, 0, 3'd7, 5, 0, 5);
        check("p5_low", 32'(bus.query_taken), 32'd0);

        // Capture, stall with new inputs, then flush+stall
        cycle(1, 1, 0, 0, 16'h0010, 16'h0020, 0, 3'd2, 2, 0, 2);
        held_cmp  = bus.cmp_result;
        held_miss = bus.miss_count;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 0, 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 2, 1'($urandom), 2);
            check("stall_cmp",   32'(bus.cmp_result), 32'(held_cmp));
            check("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        cycle(1, 1, 1, 1, 16'h0001, 16'h0002, 0, 3'd6, 2, 0, 2);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_miss",  32'(bus.miss_count), 32'(held_miss));

        // Saturate the mispredict counter, then reset mid-stream
        for (int i = 0; i < 300; i++) cycle(1, 1, 0, 0, 16'h0, 16'h0, 0, 3'd6, i % N_PRED, 0, 0);
        check("miss_sat", 32'(bus.miss_count), 32'(MISS_MAX));
        cycle(0, 1, 1, 0, 16'h0, 16'h0, 0, 3'd6, 0, 0, 0);
        check("midrst_miss",  32'(bus.miss_count), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [WIDTH-1:0] a, b;
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  a, b, 1'($urandom), 3'($urandom),
                  $urandom_range(0, N_PRED - 1), 1'($urandom),
                  $urandom_range(0, N_PRED - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
